// File: rtl/channel_forward_mux.sv
// rtl/channel_forward_mux.sv - round-robin multi-channel forwarder with overrun tracking
// Per-channel holding registers drained onto one channel-tagged valid/ready stream.
module channel_forward_mux #(
  parameter int  DATA_WIDTH    = 32,
  parameter int  CHANNEL_COUNT = 4,
  parameter bit  OVERWRITE     = 1'b1,
  localparam int CW            = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1
) (
  input  logic                                clk,
  input  logic                                rstN,
  input  logic [CHANNEL_COUNT*DATA_WIDTH-1:0] inData,
  input  logic [CHANNEL_COUNT-1:0]            inStrobe,
  output logic [DATA_WIDTH-1:0]               outData,
  output logic [CW-1:0]                       outChannel,
  output logic                                outValid,
  input  logic                                outReady,
  output logic [CHANNEL_COUNT-1:0]            pending,
  output logic [CHANNEL_COUNT-1:0]            overrun,
  input  logic [CHANNEL_COUNT-1:0]            overrunClear
);

  logic [CHANNEL_COUNT-1:0][DATA_WIDTH-1:0] holding_q, holding_d;
  logic [CHANNEL_COUNT-1:0]                 pending_q, pending_d;
  logic [CHANNEL_COUNT-1:0]                 overrun_q, overrun_d;
  logic [DATA_WIDTH-1:0]                    out_data_q, out_data_d;
  logic [CW-1:0]                            out_channel_q, out_channel_d;
  logic                                     out_valid_q, out_valid_d;
  logic [CW-1:0]                            ptr_q, ptr_d;

  logic                                     slot_free;
  logic                                     grant;
  logic [CHANNEL_COUNT-1:0]                 above_ptr;
  logic [CHANNEL_COUNT-1:0]                 masked;
  logic [CHANNEL_COUNT-1:0]                 search;
  logic [CHANNEL_COUNT-1:0]                 sel_oh;
  logic [CHANNEL_COUNT-1:0]                 ovr_set;
  logic [CHANNEL_COUNT:0][CW-1:0]           idx_chain;
  logic [CHANNEL_COUNT:0][DATA_WIDTH-1:0]   data_chain;

  assign slot_free = !out_valid_q || outReady;
  assign grant     = slot_free && (|pending_q);
  assign masked    = pending_q & above_ptr;
  assign search    = (|masked) ? masked : pending_q;
  // Lowest set bit wins: channels above the last grant first, otherwise wrap to the bottom.
  assign sel_oh    = grant ? (search & (~search + CHANNEL_COUNT'(1))) : '0;

  assign idx_chain[0]  = '0;
  assign data_chain[0] = '0;

  for (genvar k = 0; k < CHANNEL_COUNT; k++) begin : g_chan
    logic [DATA_WIDTH-1:0] word;

    assign word             = inData[k*DATA_WIDTH +: DATA_WIDTH];
    assign above_ptr[k]     = CW'(k) > ptr_q;
    assign idx_chain[k+1]   = idx_chain[k] | (sel_oh[k] ? CW'(k) : '0);
    assign data_chain[k+1]  = data_chain[k] | (sel_oh[k] ? holding_q[k] : '0);

    // A grant on the same edge frees the register, so a strobe then is a clean refill.
    assign ovr_set[k]   = inStrobe[k] && pending_q[k] && !sel_oh[k];
    assign pending_d[k] = inStrobe[k] || (pending_q[k] && !sel_oh[k]);
    assign holding_d[k] = (inStrobe[k] && (OVERWRITE || !pending_q[k] || sel_oh[k]))
                          ? word : holding_q[k];
  end

  always_comb begin
    out_data_d    = out_data_q;
    out_channel_d = out_channel_q;
    out_valid_d   = out_valid_q;
    ptr_d         = ptr_q;
    overrun_d     = (overrun_q & ~overrunClear) | ovr_set;
    if (grant) begin
      out_data_d    = data_chain[CHANNEL_COUNT];
      out_channel_d = idx_chain[CHANNEL_COUNT];
      out_valid_d   = 1'b1;
      ptr_d         = idx_chain[CHANNEL_COUNT];
    end else if (slot_free) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      holding_q     <= '0;
      pending_q     <= '0;
      overrun_q     <= '0;
      out_data_q    <= '0;
      out_channel_q <= '0;
      out_valid_q   <= 1'b0;
      ptr_q         <= CW'(CHANNEL_COUNT - 1);
    end else begin
      holding_q     <= holding_d;
      pending_q     <= pending_d;
      overrun_q     <= overrun_d;
      out_data_q    <= out_data_d;
      out_channel_q <= out_channel_d;
      out_valid_q   <= out_valid_d;
      ptr_q         <= ptr_d;
    end
  end

  assign outData    = out_data_q;
  assign outChannel = out_channel_q;
  assign outValid   = out_valid_q;
  assign pending    = pending_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_channel_forward_mux.sv
// tb/tb_channel_forward_mux.sv - bench for channel_forward_mux, both overrun policies side by side
// Instance 0 overwrites on overrun, instance 1 keeps the held word.
module tb_channel_forward_mux;

  logic         clk = 1'b0;
  logic         rstN;
  logic [127:0] inData;
  logic [3:0]   inStrobe;
  logic         outReady;
  logic [3:0]   overrunClear;

  logic [31:0] d0, d1;
  logic [1:0]  c0, c1;
  logic        v0, v1;
  logic [3:0]  p0, p1, o0, o1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  channel_forward_mux #(.DATA_WIDTH(32), .CHANNEL_COUNT(4), .OVERWRITE(1'b1)) dut_ow (
    .clk(clk), .rstN(rstN), .inData(inData), .inStrobe(inStrobe),
    .outData(d0), .outChannel(c0), .outValid(v0), .outReady(outReady),
    .pending(p0), .overrun(o0), .overrunClear(overrunClear)
  );

  channel_forward_mux #(.DATA_WIDTH(32), .CHANNEL_COUNT(4), .OVERWRITE(1'b0)) dut_keep (
    .clk(clk), .rstN(rstN), .inData(inData), .inStrobe(inStrobe),
    .outData(d1), .outChannel(c1), .outValid(v1), .outReady(outReady),
    .pending(p1), .overrun(o1), .overrunClear(overrunClear)
  );

  // Reference model: index 0 = overwrite policy, index 1 = keep policy.
  logic [31:0] m_hold  [2][4];
  logic [3:0]  m_pend  [2];
  logic [3:0]  m_ovr   [2];
  logic [31:0] m_data  [2];
  logic [1:0]  m_ch    [2];
  logic        m_valid [2];
  logic [1:0]  m_ptr   [2];

  task automatic model_reset();
    for (int mi = 0; mi < 2; mi++) begin
      logic m;
      m = 1'(mi);
      for (int ki = 0; ki < 4; ki++) m_hold[m][2'(ki)] = '0;
      m_pend[m]  = '0;
      m_ovr[m]   = '0;
      m_data[m]  = '0;
      m_ch[m]    = '0;
      m_valid[m] = 1'b0;
      m_ptr[m]   = 2'd3;
    end
  endtask

  task automatic model_step();
    for (int mi = 0; mi < 2; mi++) begin
      logic        m, free, found;
      logic [1:0]  sel, c;
      logic [3:0]  np, set;
      logic [31:0] gd, word;
      m     = 1'(mi);
      free  = !m_valid[m] || outReady;
      found = 1'b0;
      sel   = '0;
      if (free) begin
        for (int s = 1; s <= 4; s++) begin
          c = m_ptr[m] + 2'(s);
          if (!found && m_pend[m][c]) begin
            found = 1'b1;
            sel   = c;
          end
        end
      end
      gd  = m_hold[m][sel];
      np  = m_pend[m];
      set = '0;
      for (int ki = 0; ki < 4; ki++) begin
        c    = 2'(ki);
        word = 32'(inData >> (32 * ki));
        if (found && sel == c) np[c] = 1'b0;
        if (inStrobe[c]) begin
          if (m_pend[m][c] && !(found && sel == c)) begin
            set[c] = 1'b1;
            if (mi == 0) m_hold[m][c] = word;
          end else begin
            m_hold[m][c] = word;
            np[c]        = 1'b1;
          end
        end
      end
      m_ovr[m]  = (m_ovr[m] & ~overrunClear) | set;
      m_pend[m] = np;
      if (found) begin
        m_data[m]  = gd;
        m_ch[m]    = sel;
        m_valid[m] = 1'b1;
        m_ptr[m]   = sel;
      end else if (free) begin
        m_valid[m] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rstN) model_step();
    else model_reset();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    inStrobe     = '0;
    overrunClear = '0;
    rstN         = 1'b0;
    tick();
    rstN = 1'b1;
  endtask

  task automatic test_reset();
    checks++;
    if ({v0, v1, c0, c1, d0, d1} !== '0) begin
      failures++;
      $display("FAIL reset_out act=%b/%b %0d/%0d %h/%h exp=0", v0, v1, c0, c1, d0, d1);
    end
    checks++;
    if ({p0, p1, o0, o1} !== 16'h0) begin
      failures++;
      $display("FAIL reset_flags act=%b %b %b %b exp=0", p0, p1, o0, o1);
    end
  endtask

  task automatic test_single_word();
    rstN = 1'b1;
    outReady = 1'b1;
    inData = '0;
    inData[95:64] = 32'hA5A5_0002;
    inStrobe = 4'b0100;
    tick();
    inStrobe = '0;
    checks++;
    if ({v0, p0} !== {1'b0, 4'b0100}) begin
      failures++;
      $display("FAIL single_capture act=v%b p%b exp=v0 p0100", v0, p0);
    end
    tick();
    checks++;
    if ({v0, c0, d0, p0} !== {1'b1, 2'd2, 32'hA5A5_0002, 4'b0000}) begin
      failures++;
      $display("FAIL single_out act=v%b ch%0d %h p%b exp=v1 ch2 a5a50002 p0000", v0, c0, d0, p0);
    end
    checks++;
    if ({v1, c1, d1} !== {1'b1, 2'd2, 32'hA5A5_0002}) begin
      failures++;
      $display("FAIL single_out_keep act=v%b ch%0d %h exp=v1 ch2 a5a50002", v1, c1, d1);
    end
    tick();
    checks++;
    if (v0 !== 1'b0) begin
      failures++;
      $display("FAIL single_drop act=%b exp=0", v0);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    outReady = 1'b0;
    inData   = {32'h13, 32'h12, 32'h11, 32'h10};
    inStrobe = 4'hF;
    tick();
    inStrobe = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({v0, c0, d0} !== {1'b1, 2'd0, 32'h10}) begin
        failures++;
        $display("FAIL rr_stall cyc=%0d act=v%b ch%0d %h exp=v1 ch0 10", i, v0, c0, d0);
      end
    end
    outReady = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      checks++;
      if ({v0, c0, d0} !== {1'b1, 2'(i), 32'h10 + 32'(i)}) begin
        failures++;
        $display("FAIL rr_order i=%0d act=v%b ch%0d %h exp=v1 ch%0d %h", i, v0, c0, d0, i, 32'h10 + i);
      end
    end
    tick();
    checks++;
    if ({v0, p0} !== 5'b0) begin
      failures++;
      $display("FAIL rr_idle act=v%b p%b exp=v0 p0000", v0, p0);
    end
  endtask

  task automatic test_overrun();
    apply_reset();
    outReady = 1'b0;
    inData = '0;
    inData[31:0] = 32'hFF;
    inStrobe = 4'b0001;
    tick();
    inData = '0;
    inData[63:32] = 32'h1;
    inStrobe = 4'b0010;
    tick();
    inData[63:32] = 32'h2;
    tick();
    inStrobe = '0;
    checks++;
    if ({o0[1], o1[1], p0[1], p1[1]} !== 4'b1111) begin
      failures++;
      $display("FAIL ovr_flag act=o%b/%b p%b/%b exp=1111", o0[1], o1[1], p0[1], p1[1]);
    end
    outReady = 1'b1;
    tick();
    checks++;
    if ({v0, c0, d0} !== {1'b1, 2'd1, 32'h2}) begin
      failures++;
      $display("FAIL ovr_overwrite act=v%b ch%0d %h exp=v1 ch1 2", v0, c0, d0);
    end
    checks++;
    if ({v1, c1, d1} !== {1'b1, 2'd1, 32'h1}) begin
      failures++;
      $display("FAIL ovr_keep act=v%b ch%0d %h exp=v1 ch1 1", v1, c1, d1);
    end
  endtask

  task automatic test_refill();
    apply_reset();
    outReady = 1'b1;
    inData = '0;
    inData[127:96] = 32'h33;
    inStrobe = 4'b1000;
    tick();
    inData[127:96] = 32'h34;
    tick();
    inStrobe = '0;
    checks++;
    if ({v0, c0, d0, p0[3], o0[3]} !== {1'b1, 2'd3, 32'h33, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL refill_grant act=v%b ch%0d %h p%b o%b exp=v1 ch3 33 p1 o0", v0, c0, d0, p0[3], o0[3]);
    end
    checks++;
    if ({d1, p1[3], o1[3]} !== {32'h33, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL refill_grant_keep act=%h p%b o%b exp=33 p1 o0", d1, p1[3], o1[3]);
    end
    tick();
    checks++;
    if ({v0, c0, d0, v1, d1} !== {1'b1, 2'd3, 32'h34, 1'b1, 32'h34}) begin
      failures++;
      $display("FAIL refill_next act=v%b ch%0d %h / v%b %h exp=v1 ch3 34", v0, c0, d0, v1, d1);
    end
  endtask

  task automatic test_clear_vs_set();
    apply_reset();
    outReady = 1'b0;
    inData = '0;
    inData[63:32] = 32'hB1;
    inStrobe = 4'b0010;
    tick();
    inData[31:0] = 32'hA0;
    inStrobe = 4'b0001;
    tick();
    inData[31:0] = 32'hA1;
    tick();
    checks++;
    if ({o0[0], o1[0]} !== 2'b11) begin
      failures++;
      $display("FAIL clr_setup act=%b%b exp=11", o0[0], o1[0]);
    end
    inData[31:0] = 32'hA2;
    overrunClear = 4'b0001;
    tick();
    checks++;
    if ({o0[0], o1[0]} !== 2'b11) begin
      failures++;
      $display("FAIL clr_vs_set act=%b%b exp=11", o0[0], o1[0]);
    end
    inStrobe = '0;
    tick();
    overrunClear = '0;
    checks++;
    if ({o0[0], o1[0]} !== 2'b00) begin
      failures++;
      $display("FAIL clr_alone act=%b%b exp=00", o0[0], o1[0]);
    end
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    outReady = 1'b0;
    inData   = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    inStrobe = 4'b1011;
    tick();
    inStrobe = '0;
    tick();
    checks++;
    if ({v0, p0} !== {1'b1, 4'b1010}) begin
      failures++;
      $display("FAIL mid_setup act=v%b p%b exp=v1 p1010", v0, p0);
    end
    #2;
    rstN = 1'b0;
    #1;
    checks++;
    if ({v0, c0, d0, p0, o0, v1, p1} !== '0) begin
      failures++;
      $display("FAIL mid_async act=v%b ch%0d %h p%b o%b v%b p%b exp=0", v0, c0, d0, p0, o0, v1, p1);
    end
    tick();
    rstN     = 1'b1;
    outReady = 1'b1;
    inData   = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    inStrobe = 4'b1100;
    tick();
    inStrobe = '0;
    tick();
    checks++;
    if ({v0, c0, d0} !== {1'b1, 2'd2, 32'hD2}) begin
      failures++;
      $display("FAIL mid_first_grant act=v%b ch%0d %h exp=v1 ch2 d2", v0, c0, d0);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      inData   = {$urandom, $urandom, $urandom, $urandom};
      inStrobe = (cyc % 200 < 100) ? 4'($urandom) : 4'($urandom & $urandom);
      outReady = ($urandom_range(0, 3) != 0);
      overrunClear = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
      tick();
      for (int mi = 0; mi < 2; mi++) begin
        logic        m, av;
        logic [3:0]  ap, ao;
        logic [31:0] ad;
        logic [1:0]  ac;
        m  = 1'(mi);
        av = m ? v1 : v0;
        ap = m ? p1 : p0;
        ao = m ? o1 : o0;
        ad = m ? d1 : d0;
        ac = m ? c1 : c0;
        checks++;
        if ({av, ap, ao} !== {m_valid[m], m_pend[m], m_ovr[m]}) begin
          failures++;
          $display("FAIL rand_state inst=%0d cyc=%0d act=v%b p%b o%b exp=v%b p%b o%b",
                   mi, cyc, av, ap, ao, m_valid[m], m_pend[m], m_ovr[m]);
        end
        if (m_valid[m]) begin
          checks++;
          if ({ac, ad} !== {m_ch[m], m_data[m]}) begin
            failures++;
            $display("FAIL rand_out inst=%0d cyc=%0d act=ch%0d %h exp=ch%0d %h",
                     mi, cyc, ac, ad, m_ch[m], m_data[m]);
          end
        end
      end
    end
    inStrobe     = '0;
    overrunClear = '0;
  endtask

  initial begin
    rstN         = 1'b0;
    inData       = '0;
    inStrobe     = '0;
    outReady     = 1'b0;
    overrunClear = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single_word();
    test_round_robin();
    test_overrun();
    test_refill();
    test_clear_vs_set();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/channel_forward_mux.md
# channel_forward_mux

Single-clock, multi-channel forwarding stage that collects strobed words from CHANNEL_COUNT independent producers into per-channel holding registers. It drains them onto one valid/ready output stream tagged with the channel number, using round-robin arbitration. It sits downstream of the per-channel clock-crossing forwarders and feeds the single event/diagnostic stream. It adds per-channel pending tracking, overrun detection and a selectable overwrite/drop policy, none of which a plain forwarder has.

## Interface
- DATA_WIDTH, 32, width of each channel word
- CHANNEL_COUNT, 4, number of input channels (1..16)
- OVERWRITE, 1, overrun policy: 1 = newest word replaces held word, 0 = held word kept, new word dropped
- CW (localparam) = max(1, $clog2(CHANNEL_COUNT))
- clk  input  1  sole clock; all logic on rising edge
- rstN  input  1  asynchronous, active-low reset
- inData  input  CHANNEL_COUNT*DATA_WIDTH  channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- inStrobe  input  CHANNEL_COUNT  bit k high for one cycle = inData word k valid
- outData  output  DATA_WIDTH  forwarded word
- outChannel  output  CW  channel index of outData
- outValid  output  1  outData/outChannel valid
- outReady  input  1  consumer accepts when outValid & outReady at a rising edge
- pending  output  CHANNEL_COUNT  bit k = channel k holding register occupied
- overrun  output  CHANNEL_COUNT  sticky per-channel overrun flag
- overrunClear  input  CHANNEL_COUNT  bit k clears overrun[k]

## Operation
- Reset (rstN low, asynchronous): outData=0, outChannel=0, outValid=0, pending=0, overrun=0, holding registers=0. The round-robin pointer is set to CHANNEL_COUNT-1, so channel 0 has first priority.
- Capture for channel k, inStrobe[k] at an edge:
  - pending[k]=0, or channel k granted at the same edge: holding[k] <= word, pending[k] <= 1, no overrun.
  - pending[k]=1 and not granted: overrun[k] <= 1. With OVERWRITE=1, holding[k] <= word; with OVERWRITE=0, holding[k] is unchanged. pending[k] stays 1.
- Output slot is free when outValid=0, or when outValid & outReady at this edge.
- Grant when the slot is free and any pending bit is set:
  - Select the first pending channel searching upward from pointer+1, wrapping modulo CHANNEL_COUNT.
  - Load outData <= holding[sel], outChannel <= sel, outValid <= 1.
  - Clear pending[sel] unless a simultaneous strobe refills it (capture rules above). The pointer <= sel.
- Slot free and nothing pending: outValid <= 0.
- Stability: while outValid & !outReady, outData and outChannel must not change.
- overrunClear[k] clears overrun[k]. A same-edge overrun event on k wins, and the flag stays 1.
- With CHANNEL_COUNT=1 the arbiter degenerates; outChannel is always 0.

## Timing
- Strobe at edge n: pending high after edge n. The earliest grant is at edge n+1, so outValid is first high in cycle n+1 (latency 1 edge after capture, 2 edges strobe-to-accept minimum).
- Throughput: one word per cycle while outReady=1 and words are pending. There are no bubbles between back-to-back grants.
- Fairness: with all channels continuously pending, grants cycle 0,1,…,CHANNEL_COUNT-1,0,…; no channel waits more than CHANNEL_COUNT grants.
- pending and overrun are registered outputs, with no combinational path from inputs.
- outValid depends combinationally on nothing. outReady affects only next-state logic.

## Test plan
- Reset mid-stream: with outValid=1 and pending=4'b1010, assert rstN=0 between edges -> outputs, pending and overrun are all 0 immediately. After release, the first grant goes to the lowest-index pending channel.
- Single word: CHANNEL_COUNT=4, inStrobe=4'b0100 with word 0xA5A5_0002, outReady=1 -> the next cycle shows outValid=1, outChannel=2, outData=0xA5A5_0002, pending=0. outValid then drops.
- Round robin under backpressure: strobe all four channels with 0x10..0x13 at once, outReady=0 for 5 cycles then 1 -> outData holds 0x10/channel 0 while stalled. Then 0x11, 0x12, 0x13 follow on consecutive cycles.
- Overrun OVERWRITE=1: outReady=0, strobe channel 1 with 0x1, then 0x2 -> overrun[1]=1; the forwarded word is 0x2. Repeat with OVERWRITE=0 -> the forwarded word is 0x1.
- Refill on grant: channel 3 pending with 0x33 and the slot is free. Strobe 0x34 on channel 3 at the grant edge -> output is 0x33, pending[3] stays 1, overrun[3]=0. The next grant outputs 0x34.
- Clear vs set: overrun[0]=1. Assert overrunClear[0] in the same cycle as a new channel-0 overrun -> overrun[0] stays 1. Clear alone the next cycle -> 0.
